// File: rtl/ans_decode_scheduler.sv
// Sequences one ANS range calculator through a slice decode: word credit flow into the
// calculator FIFO, symbol lookup handshake, state update strobes and symbol emission.
module ans_decode_scheduler #(
    parameter int                     BITSTREAM_WIDTH = 32,
    parameter int                     STATE_WIDTH     = 32,
    parameter int                     SYM_W           = 8,
    parameter int                     CNT_W           = 16,
    parameter int                     FIFO_DEPTH      = 4,
    parameter logic [STATE_WIDTH-1:0] RENORM_THRESH   = 'h1000,
    parameter int                     TIMEOUT_CYC     = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       slice_start,
    input  logic [CNT_W-1:0]           slice_sym_count,
    output logic                       slice_busy,
    output logic                       slice_done,
    output logic                       error,
    input  logic [BITSTREAM_WIDTH-1:0] word_in,
    input  logic                       word_valid,
    output logic                       word_ready,
    output logic [BITSTREAM_WIDTH-1:0] rc_bitstream_in,
    output logic                       rc_bitstream_valid,
    input  logic [STATE_WIDTH-1:0]     rc_state,
    input  logic                       rc_state_valid,
    output logic                       rc_state_update,
    output logic [STATE_WIDTH-1:0]     rc_next_state,
    output logic                       sym_req,
    output logic [STATE_WIDTH-1:0]     sym_state,
    input  logic                       sym_ack,
    input  logic [STATE_WIDTH-1:0]     sym_next_state,
    input  logic [SYM_W-1:0]           sym_value,
    output logic [SYM_W-1:0]           sym_out,
    output logic                       sym_out_valid,
    input  logic                       sym_out_ready
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_UPDATE, S_SETTLE, S_EMIT, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [OCC_W-1:0]       occ_q;
    logic [CNT_W-1:0]       remaining_q;
    logic [TMO_W-1:0]       stall_cnt_q;
    logic                   error_q;
    logic                   have_state_q;
    logic [STATE_WIDTH-1:0] sym_state_q;
    logic [STATE_WIDTH-1:0] next_state_q;
    logic [SYM_W-1:0]       sym_q;

    logic renorm, stall, timeout, ack_take, emit_take, pop;

    assign error              = error_q;
    assign rc_next_state      = next_state_q;
    assign sym_state          = sym_state_q;
    assign sym_out            = sym_q;
    assign word_ready         = slice_busy && (occ_q < OCC_FULL);
    assign rc_bitstream_in    = word_in;
    assign rc_bitstream_valid = word_valid && word_ready;

    // A renormalising update consumes one buffered word, so it may only issue with occ > 0
    assign renorm    = next_state_q < RENORM_THRESH;
    assign stall     = (state_q == S_UPDATE) && renorm && (occ_q == '0);
    assign timeout   = stall && (stall_cnt_q == TMO_LAST);
    assign ack_take  = sym_req && sym_ack;
    assign emit_take = sym_out_valid && sym_out_ready;
    assign pop       = rc_state_update && renorm;

    always_comb begin
        state_d         = state_q;
        slice_busy      = (state_q != S_IDLE);
        slice_done      = 1'b0;
        sym_req         = 1'b0;
        rc_state_update = 1'b0;
        sym_out_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (slice_start)
                    state_d = (slice_sym_count == '0) ? S_DONE : S_LOOKUP;
            end
            S_LOOKUP: begin
                sym_req = have_state_q;
                if (have_state_q && sym_ack)
                    state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (stall) begin
                    if (stall_cnt_q == TMO_LAST)
                        state_d = S_DONE;
                end else begin
                    rc_state_update = 1'b1;
                    state_d         = S_SETTLE;
                end
            end
            S_SETTLE: state_d = S_EMIT;
            S_EMIT: begin
                sym_out_valid = 1'b1;
                if (sym_out_ready)
                    state_d = (remaining_q == CNT_W'(1)) ? S_DONE : S_LOOKUP;
            end
            S_DONE: begin
                slice_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            occ_q        <= '0;
            remaining_q  <= '0;
            stall_cnt_q  <= '0;
            error_q      <= 1'b0;
            have_state_q <= 1'b0;
            sym_state_q  <= '0;
            next_state_q <= '0;
            sym_q        <= '0;
        end else begin
            state_q <= state_d;

            if (rc_bitstream_valid && !pop)
                occ_q <= occ_q + 1'b1;
            else if (pop && !rc_bitstream_valid)
                occ_q <= occ_q - 1'b1;

            if (state_q == S_IDLE && slice_start) begin
                remaining_q <= slice_sym_count;
                error_q     <= 1'b0;
            end else if (emit_take) begin
                remaining_q <= remaining_q - 1'b1;
            end
            if (timeout)
                error_q <= 1'b1;

            stall_cnt_q <= (stall && !timeout) ? stall_cnt_q + 1'b1 : '0;

            // Lookup state is captured on LOOKUP entry, or later if the calculator was not yet valid
            if (state_d == S_LOOKUP && state_q != S_LOOKUP) begin
                have_state_q <= rc_state_valid;
                sym_state_q  <= rc_state;
            end else if (state_q == S_LOOKUP && !have_state_q && rc_state_valid) begin
                have_state_q <= 1'b1;
                sym_state_q  <= rc_state;
            end else if (ack_take) begin
                have_state_q <= 1'b0;
            end

            if (ack_take) begin
                next_state_q <= sym_next_state;
                sym_q        <= sym_value;
            end
        end
    end

endmodule

// File: tb/tb_ans_decode_scheduler.sv
// Randomised bench for ans_decode_scheduler: behavioural lookup/calculator/word-source
// models plus a scoreboard tracking buffered words, expected updates and symbols.
module tb_ans_decode_scheduler;

    localparam int          DEPTH = 4;
    localparam int          TMO   = 1024;
    localparam logic [31:0] THR   = 32'h1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slice_start = 1'b0;
    logic [15:0] slice_sym_count = '0;
    logic        slice_busy, slice_done, error;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [31:0] rc_bitstream_in;
    logic        rc_bitstream_valid;
    logic [31:0] rc_state = '0;
    logic        rc_state_valid = 1'b1;
    logic        rc_state_update;
    logic [31:0] rc_next_state;
    logic        sym_req;
    logic [31:0] sym_state;
    logic        sym_ack = 1'b0;
    logic [31:0] sym_next_state = '0;
    logic [7:0]  sym_value = '0;
    logic [7:0]  sym_out;
    logic        sym_out_valid;
    logic        sym_out_ready = 1'b0;

    ans_decode_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .slice_start(slice_start), .slice_sym_count(slice_sym_count),
        .slice_busy(slice_busy), .slice_done(slice_done), .error(error),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .rc_bitstream_in(rc_bitstream_in), .rc_bitstream_valid(rc_bitstream_valid),
        .rc_state(rc_state), .rc_state_valid(rc_state_valid),
        .rc_state_update(rc_state_update), .rc_next_state(rc_next_state),
        .sym_req(sym_req), .sym_state(sym_state), .sym_ack(sym_ack),
        .sym_next_state(sym_next_state), .sym_value(sym_value),
        .sym_out(sym_out), .sym_out_valid(sym_out_valid), .sym_out_ready(sym_out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: words held by the calculator FIFO, outstanding updates/symbols, event counters
    int          m_occ = 0;
    int          words_left = 0;
    int          n_updates = 0, n_emits = 0, n_done = 0, n_req = 0, n_pushes = 0, n_both = 0;
    logic [31:0] ns_q[$];
    logic [7:0]  sym_q[$];
    logic [31:0] m_calc = '0;
    logic        m_acked = 1'b0;
    bit          mon_en = 0;

    // Stimulus knobs
    int          push_mode = 0;
    bit          ns_rand = 0;
    logic [31:0] ns_fixed = 32'h2000;
    bit          ready_rand = 0;
    logic        ready_val = 1'b1;
    bit          ack_noise = 0;
    bit          vld_rand = 0;

    // Lookup table, calculator register and downstream sink
    always @(posedge clk) begin
        logic [31:0] ns;
        #1;
        sym_ack = 1'b0;
        if (rst_n && sym_req) begin
            if (ns_rand)
                ns = ($urandom % 2 == 1) ? ($urandom % THR) : (THR + ($urandom % 32'h100000));
            else
                ns = ns_fixed;
            sym_ack        = 1'b1;
            sym_next_state = ns;
            sym_value      = 8'($urandom);
            ns_q.push_back(ns);
            sym_q.push_back(sym_value);
        end else begin
            sym_ack        = ack_noise && ($urandom % 4 == 0);
            sym_next_state = $urandom;
            sym_value      = 8'($urandom);
        end
        rc_state       = m_calc;
        rc_state_valid = vld_rand ? ($urandom % 4 != 0) : 1'b1;
        sym_out_ready  = ready_rand ? 1'($urandom % 2) : ready_val;
    end

    // Bitstream word source
    always @(posedge clk) begin
        #2;
        word_in = $urandom;
        case (push_mode)
            1:       word_valid = (words_left > 0);
            2:       word_valid = m_acked && (words_left > 0);
            3:       word_valid = ($urandom % 2 == 1);
            default: word_valid = 1'b0;
        endcase
    end

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (rc_bitstream_in !== word_in || rc_bitstream_valid !== (word_valid && word_ready))
                $display("FAIL word_passthru: got valid=%0b data=%h, need valid=%0b data=%h",
                         rc_bitstream_valid, rc_bitstream_in, word_valid && word_ready, word_in);
            else n_pass++;
            n_checks++;
            if (word_ready !== (slice_busy && (m_occ < DEPTH)))
                $display("FAIL word_ready: got %0b need %0b (occ %0d)", word_ready,
                         slice_busy && (m_occ < DEPTH), m_occ);
            else n_pass++;
            if (sym_req) begin
                n_req++;
                n_checks++;
                if (sym_state !== m_calc)
                    $display("FAIL sym_state: got %h need %h", sym_state, m_calc);
                else n_pass++;
            end
            if (rc_state_update) begin
                n_updates++;
                n_checks++;
                if (ns_q.size() == 0) begin
                    $display("FAIL update_unexpected: got update %h, need none", rc_next_state);
                end else begin
                    if (rc_next_state !== ns_q[0])
                        $display("FAIL next_state: got %h need %h", rc_next_state, ns_q[0]);
                    else n_pass++;
                    if (ns_q[0] < THR) begin
                        n_checks++;
                        if (m_occ == 0) $display("FAIL renorm_empty: got update with occ 0, need stall");
                        else n_pass++;
                        m_occ--;
                    end
                    m_calc = ns_q.pop_front();
                end
            end
            if (rc_bitstream_valid) begin
                m_occ++;
                n_pushes++;
                if (words_left > 0) words_left--;
                if (rc_state_update) n_both++;
            end
            if (sym_out_valid && sym_out_ready) begin
                n_emits++;
                n_checks++;
                if (sym_q.size() == 0)
                    $display("FAIL sym_unexpected: got %h need none", sym_out);
                else if (sym_out !== sym_q[0])
                    $display("FAIL sym_out: got %h need %h", sym_out, sym_q[0]);
                else n_pass++;
                if (sym_q.size() != 0) void'(sym_q.pop_front());
            end
            if (slice_done) n_done++;
            m_acked = sym_req && sym_ack;
            if (!rst_n) begin
                m_occ = 0;
                m_calc = '0;
                ns_q.delete();
                sym_q.delete();
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic start_slice(input int cnt);
        @(posedge clk); #1 slice_start = 1'b1; slice_sym_count = 16'(cnt);
        @(posedge clk); #1 slice_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        bit seen = 0;
        for (cyc = 0; cyc < maxc; cyc++) begin
            @(negedge clk);
            if (slice_done) begin seen = 1; break; end
        end
        n_checks++;
        if (!seen) $display("FAIL done_timeout: got no slice_done in %0d cycles, need one", maxc);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({slice_busy, slice_done, error, word_ready, rc_bitstream_valid, rc_state_update,
             sym_req, sym_out_valid} !== 8'h00)
            $display("FAIL reset_ctrl: got %b need 00000000", {slice_busy, slice_done, error,
                     word_ready, rc_bitstream_valid, rc_state_update, sym_req, sym_out_valid});
        else n_pass++;
        n_checks++;
        if ({rc_next_state, sym_state, sym_out} !== '0)
            $display("FAIL reset_data: got %h/%h/%h need 0", rc_next_state, sym_state, sym_out);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        mon_en = 1;
    endtask

    task automatic test_basic();
        int c, bu, be, bd, bp;
        bu = n_updates; be = n_emits; bd = n_done; bp = n_pushes;
        push_mode = 1; words_left = 4; ns_fixed = 32'h2000; ready_val = 1'b1;
        start_slice(3);
        wait_done(200, c);
        n_checks++;
        if (c != 12) $display("FAIL basic_latency: got %0d cycles need 12", c); else n_pass++;
        n_checks++;
        if (n_updates - bu != 3 || n_emits - be != 3 || n_done - bd != 1)
            $display("FAIL basic_counts: got upd=%0d emit=%0d done=%0d need 3/3/1",
                     n_updates - bu, n_emits - be, n_done - bd);
        else n_pass++;
        n_checks++;
        if (n_pushes - bp != 4 || m_occ != 4)
            $display("FAIL basic_occ: got pushes=%0d occ=%0d need 4/4", n_pushes - bp, m_occ);
        else n_pass++;
        n_checks++;
        if (slice_busy !== 1'b0 || error !== 1'b0)
            $display("FAIL basic_idle: got busy=%0b err=%0b need 0/0", slice_busy, error);
        else n_pass++;
        push_mode = 0;
    endtask

    task automatic test_count0();
        int c, bu, br, bd;
        bu = n_updates; br = n_req; bd = n_done;
        start_slice(0);
        wait_done(5, c);
        n_checks++;
        if (c != 0) $display("FAIL count0_latency: got %0d need 0", c); else n_pass++;
        n_checks++;
        if (n_updates - bu != 0 || n_req - br != 0 || n_done - bd != 1)
            $display("FAIL count0_activity: got upd=%0d req=%0d done=%0d need 0/0/1",
                     n_updates - bu, n_req - br, n_done - bd);
        else n_pass++;
        n_checks++;
        if (slice_busy !== 1'b0) $display("FAIL count0_idle: got busy=%0b need 0", slice_busy);
        else n_pass++;
    endtask

    task automatic test_stall();
        int c, bu, be;
        do_reset();
        bu = n_updates; be = n_emits;
        push_mode = 1; words_left = 1; ns_fixed = 32'h0800; ready_val = 1'b1;
        start_slice(2);
        for (int i = 0; i < 50 && n_updates - bu < 1; i++) begin @(posedge clk); #1; end
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (n_updates - bu != 1 || slice_busy !== 1'b1 || m_occ != 0)
            $display("FAIL stall_hold: got upd=%0d busy=%0b occ=%0d need 1/1/0",
                     n_updates - bu, slice_busy, m_occ);
        else n_pass++;
        words_left = 1;
        wait_done(50, c);
        n_checks++;
        if (n_updates - bu != 2 || n_emits - be != 2 || m_occ != 0 || error !== 1'b0)
            $display("FAIL stall_resume: got upd=%0d emit=%0d occ=%0d err=%0b need 2/2/0/0",
                     n_updates - bu, n_emits - be, m_occ, error);
        else n_pass++;
        push_mode = 0;
    endtask

    task automatic test_full_concurrent();
        int c, bb, bp;
        do_reset();
        push_mode = 1; words_left = 3; ns_fixed = 32'h2000; ready_val = 1'b1;
        start_slice(1);
        wait_done(50, c);
        bb = n_both;
        push_mode = 2; words_left = 1; ns_fixed = 32'h0800;
        start_slice(1);
        wait_done(50, c);
        n_checks++;
        if (n_both - bb != 1 || m_occ != 3)
            $display("FAIL push_and_renorm: got both=%0d occ=%0d need 1/3", n_both - bb, m_occ);
        else n_pass++;
        bp = n_pushes;
        push_mode = 1; words_left = 10; ns_fixed = 32'h2000; ready_val = 1'b0;
        start_slice(1);
        for (int i = 0; i < 20 && !sym_out_valid; i++) @(negedge clk);
        n_checks++;
        if (n_pushes - bp != 1 || word_valid !== 1'b1 || word_ready !== 1'b0)
            $display("FAIL full_credit: got pushes=%0d valid=%0b ready=%0b need 1/1/0",
                     n_pushes - bp, word_valid, word_ready);
        else n_pass++;
        ready_val = 1'b1;
        wait_done(20, c);
        push_mode = 0; words_left = 0;
    endtask

    task automatic test_timeout();
        int c, bu;
        do_reset();
        bu = n_updates;
        push_mode = 0; ns_fixed = 32'h0100;
        start_slice(1);
        wait_done(TMO + 100, c);
        n_checks++;
        if (c != TMO + 1 || error !== 1'b1 || n_updates != bu)
            $display("FAIL timeout: got cyc=%0d err=%0b upd=%0d need %0d/1/0",
                     c, error, n_updates - bu, TMO + 1);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (error !== 1'b1 || slice_busy !== 1'b0)
            $display("FAIL error_sticky: got err=%0b busy=%0b need 1/0", error, slice_busy);
        else n_pass++;
        start_slice(0);
        n_checks++;
        if (error !== 1'b0) $display("FAIL error_clear: got %0b need 0", error); else n_pass++;
        wait_done(5, c);
        ns_q.delete();
        sym_q.delete();
    endtask

    task automatic test_reset_emit();
        int bd;
        do_reset();
        push_mode = 1; words_left = 2; ns_fixed = 32'h2000; ready_val = 1'b0;
        start_slice(2);
        for (int i = 0; i < 20 && !sym_out_valid; i++) @(negedge clk);
        n_checks++;
        if (sym_out_valid !== 1'b1) $display("FAIL emit_reach: got valid=0 need 1"); else n_pass++;
        bd = n_done;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({slice_busy, slice_done, error, word_ready, rc_bitstream_valid, rc_state_update,
             sym_req, sym_out_valid} !== 8'h00 || {rc_next_state, sym_state, sym_out} !== '0)
            $display("FAIL reset_emit: got ctrl=%b out=%h need all 0", {slice_busy, slice_done,
                     error, word_ready, rc_bitstream_valid, rc_state_update, sym_req,
                     sym_out_valid}, sym_out);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        ready_val = 1'b1; push_mode = 0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (n_done != bd || slice_busy !== 1'b0)
            $display("FAIL reset_no_done: got done=%0d busy=%0b need 0/0", n_done - bd, slice_busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c, cnt, be, bd;
        push_mode = 3; ns_rand = 1; ready_rand = 1; ack_noise = 1; vld_rand = 1;
        for (int s = 0; s < 6; s++) begin
            cnt = $urandom_range(1, 6);
            be = n_emits; bd = n_done;
            start_slice(cnt);
            wait_done(2000, c);
            n_checks++;
            if (n_emits - be != cnt || n_done - bd != 1 || error !== 1'b0)
                $display("FAIL random_slice%0d: got emit=%0d done=%0d err=%0b need %0d/1/0",
                         s, n_emits - be, n_done - bd, error, cnt);
            else n_pass++;
            n_checks++;
            if (ns_q.size() != 0 || sym_q.size() != 0)
                $display("FAIL random_drain%0d: got %0d/%0d pending need 0/0",
                         s, ns_q.size(), sym_q.size());
            else n_pass++;
        end
        push_mode = 0; ns_rand = 0; ready_rand = 0; ack_noise = 0; vld_rand = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_count0();
        test_stall();
        test_full_concurrent();
        test_timeout();
        test_reset_emit();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
